// File: rtl/tremolo_pkg.sv
// Shared types and constants for the tremolo modulator.
package tremolo_pkg;

   localparam int DEPTH_W   = 3;
   localparam int LFO_SHIFT = 15;
   localparam int LFOQ_W    = 16;
   localparam int GAIN_W    = 16;
   localparam int GAIN_FRAC = 15;

   localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'd32768;

   typedef enum logic [1:0] {
      S_BYPASS,
      S_RUN,
      S_RELEASE
   } state_t;

   // LFO word scaled down to a 16-bit modulation value, clamped so that
   // out-of-range LFO words cannot wrap the gain computation.
   function automatic logic signed [LFOQ_W-1:0] sat_lfo(input logic signed [31:0] lfo);
      logic signed [31:0]       sh;
      logic signed [LFOQ_W-1:0] res;
      sh = lfo >>> LFO_SHIFT;
      if (sh > 32'sd32767)
         res = 16'sh7FFF;
      else if (sh < -32'sd32768)
         res = 16'sh8000;
      else
         res = LFOQ_W'(sh);
      return res;
   endfunction

endpackage

// File: rtl/tremolo_modulator_if.sv
// Sample/control bundle between the audio source, the modulator and the DAC path.
interface tremolo_modulator_if
   import tremolo_pkg::*;
#(
   parameter int DATA_W = 16
);
   logic                     i_start;
   logic [DEPTH_W-1:0]       i_depth;
   logic signed [31:0]       i_lfo;
   logic                     i_valid;
   logic signed [DATA_W-1:0] i_sample;
   logic                     o_valid;
   logic signed [DATA_W-1:0] o_sample;
   logic                     o_active;
   logic [DEPTH_W-1:0]       o_eff_depth;

   modport master (
      output i_start, i_depth, i_lfo, i_valid, i_sample,
      input  o_valid, o_sample, o_active, o_eff_depth
   );

   modport slave (
      input  i_start, i_depth, i_lfo, i_valid, i_sample,
      output o_valid, o_sample, o_active, o_eff_depth
   );
endinterface

// File: rtl/tremolo_gain.sv
// Combinational gain: maps the scaled LFO value and current depth to a
// Q1.15 unsigned gain in 4097..32768. Bypass forces unity.
module tremolo_gain
   import tremolo_pkg::*;
(
   input  logic signed [LFOQ_W-1:0] lfo_q,
   input  logic [DEPTH_W-1:0]       eff_depth,
   input  logic                     bypass,
   output logic [GAIN_W-1:0]        gain
);
   logic [15:0] m;
   logic [15:0] a;
   logic [18:0] scaled;

   // a = distance of the LFO below its rest peak; the deeper the trough, the more attenuation
   always_comb begin
      m      = $unsigned(lfo_q) + 16'h8000;
      a      = 16'hFFFF - m;
      scaled = 19'(a) * 19'(eff_depth);
      gain   = bypass ? UNITY_GAIN : UNITY_GAIN - GAIN_W'(scaled >> 4);
   end

endmodule

// File: rtl/tremolo_modulator.sv
// Tremolo (amplitude modulation) of a signed PCM stream by the triangle LFO.
// 3-stage pipeline, one sample per cycle; depth changes ramp one step per
// RAMP_SAMPLES accepted samples. Define TREMOLO_ROUND_EN to round the final
// product half-up instead of truncating.
module tremolo_modulator
   import tremolo_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int RAMP_SAMPLES = 256
) (
   input logic                i_clk,
   input logic                i_rst_n,
   tremolo_modulator_if.slave bus
);
   localparam int CNT_W  = $clog2(RAMP_SAMPLES);
   localparam int STAGES = 3;
   localparam int PROD_W = DATA_W + 17;

   state_t                   state;
   logic [CNT_W-1:0]         ramp_cnt;
   logic [DEPTH_W-1:0]       eff_depth;
   logic                     wrap;
   logic [STAGES:1]          vld_pipe;
   logic signed [DATA_W-1:0] s1_sample;
   logic signed [LFOQ_W-1:0] s1_lfo_q;
   logic signed [DATA_W-1:0] s2_sample;
   logic [GAIN_W-1:0]        gain;
   logic [GAIN_W-1:0]        s2_gain;
   logic signed [PROD_W-1:0] prod;
   logic signed [DATA_W-1:0] out_sample;

   assign wrap = bus.i_valid && (ramp_cnt == CNT_W'(RAMP_SAMPLES - 1));

   // Effect state, ramp counter and ramped depth; a start/stop change beats a coincident depth step
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_BYPASS;
         ramp_cnt  <= '0;
         eff_depth <= '0;
      end else begin
         case (state)
            S_BYPASS: begin
               ramp_cnt  <= '0;
               eff_depth <= '0;
               if (bus.i_start)
                  state <= S_RUN;
            end
            S_RUN: begin
               if (bus.i_valid)
                  ramp_cnt <= ramp_cnt + 1'b1;
               if (!bus.i_start)
                  state <= S_RELEASE;
               else if (wrap) begin
                  if (eff_depth < bus.i_depth)
                     eff_depth <= eff_depth + 1'b1;
                  else if (eff_depth > bus.i_depth)
                     eff_depth <= eff_depth - 1'b1;
               end
            end
            S_RELEASE: begin
               if (bus.i_start) begin
                  state <= S_RUN;
                  if (bus.i_valid)
                     ramp_cnt <= ramp_cnt + 1'b1;
               end else if (eff_depth == '0) begin
                  state    <= S_BYPASS;
                  ramp_cnt <= '0;
               end else begin
                  if (bus.i_valid)
                     ramp_cnt <= ramp_cnt + 1'b1;
                  if (wrap)
                     eff_depth <= eff_depth - 1'b1;
               end
            end
            default: begin
               state    <= S_BYPASS;
               ramp_cnt <= '0;
            end
         endcase
      end
   end

   // Valid shift register; reset drops every in-flight sample
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         vld_pipe <= '0;
      else
         vld_pipe <= {vld_pipe[STAGES-1:1], bus.i_valid};
   end

   // Stage 1: capture sample and saturated LFO value
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_sample <= '0;
         s1_lfo_q  <= '0;
      end else if (bus.i_valid) begin
         s1_sample <= bus.i_sample;
         s1_lfo_q  <= sat_lfo(bus.i_lfo);
      end
   end

   tremolo_gain u_gain (
      .lfo_q     (s1_lfo_q),
      .eff_depth (eff_depth),
      .bypass    (state == S_BYPASS),
      .gain      (gain)
   );

   // Stage 2: capture gain computed from the depth current at this stage
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_sample <= '0;
         s2_gain   <= '0;
      end else if (vld_pipe[1]) begin
         s2_sample <= s1_sample;
         s2_gain   <= gain;
      end
   end

   // Signed product; gain is at most unity so the shifted result always fits
   always_comb begin
      prod = PROD_W'(s2_sample) * PROD_W'($signed({1'b0, s2_gain}));
`ifdef TREMOLO_ROUND_EN
      prod = prod + PROD_W'(1 << (GAIN_FRAC - 1));
`endif
   end

   // Stage 3: scale back to sample width
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         out_sample <= '0;
      else if (vld_pipe[2])
         out_sample <= DATA_W'(prod >>> GAIN_FRAC);
   end

   assign bus.o_valid     = vld_pipe[STAGES];
   assign bus.o_sample    = out_sample;
   assign bus.o_active    = (state != S_BYPASS);
   assign bus.o_eff_depth = eff_depth;

endmodule

// File: tb/tb_tremolo_modulator.sv
// Self-checking bench for tremolo_modulator: random samples and LFO words
// checked against an arithmetic reference and a sample-count depth model.
module tb_tremolo_modulator;
   import tremolo_pkg::*;

   localparam int DATA_W   = 16;
   localparam int RAMP     = 256;
   localparam int MODE_BYP = 0;
   localparam int MODE_RUN = 1;
   localparam int MODE_REL = 2;
   localparam logic signed [31:0] LFO_MIN  = -32'sd1073741824;
   localparam logic signed [31:0] LFO_REST = 32'sd1073741824;
`ifdef TREMOLO_ROUND_EN
   localparam int EXP_FULL = 2049;
   localparam int EXP_D4   = -6000;
`else
   localparam int EXP_FULL = 2048;
   localparam int EXP_D4   = -6001;
`endif

   typedef struct {
      bit v;
      int s;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   m_mode, m_eff, m_cnt;
   exp_t exq[$];

   tremolo_modulator_if #(.DATA_W(DATA_W)) bus ();

   tremolo_modulator #(.DATA_W(DATA_W), .RAMP_SAMPLES(RAMP)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Output expected from the arithmetic definition of the effect
   function automatic int ref_out(input int sample, input logic signed [31:0] lfo, input int depth);
      longint q, gain, prod;
      q = lfo;
      q = q >>> 15;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      gain = 32768 - ((32767 - q) * depth) / 16;
      prod = sample * gain;
`ifdef TREMOLO_ROUND_EN
      prod = prod + 16384;
`endif
      return int'(prod >>> 15);
   endfunction

   function automatic logic signed [31:0] rand_lfo();
      logic signed [31:0] r;
      case ($urandom_range(4))
         0:       r = LFO_MIN;
         1:       r = LFO_REST;
         2:       r = 32'sd0;
         3:       r = $signed($urandom_range(32'h7FFF_FFFF)) - 32'sd1073741824;
         default: r = $signed($urandom);
      endcase
      return r;
   endfunction

   function automatic int rand_sample();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   task automatic model_reset();
      exp_t idle;
      idle.v = 1'b0;
      idle.s = 0;
      m_mode = MODE_BYP;
      m_eff  = 0;
      m_cnt  = 0;
      exq.delete();
      exq.push_back(idle);
      exq.push_back(idle);
   endtask

   // Depth follows wraps of the accepted-sample count since the effect started
   task automatic model_edge(input bit v, input bit start, input int depth);
      if (m_mode == MODE_BYP) begin
         m_eff = 0;
         m_cnt = 0;
         if (start) m_mode = MODE_RUN;
      end else if (m_mode == MODE_RUN) begin
         if (v) m_cnt++;
         if (!start) m_mode = MODE_REL;
         else if (v && m_cnt % RAMP == 0) begin
            if (depth > m_eff) m_eff++;
            else if (depth < m_eff) m_eff--;
         end
      end else begin
         if (start) begin
            m_mode = MODE_RUN;
            if (v) m_cnt++;
         end else if (m_eff == 0) begin
            m_mode = MODE_BYP;
            m_cnt  = 0;
         end else begin
            if (v) m_cnt++;
            if (v && m_cnt % RAMP == 0) m_eff--;
         end
      end
   endtask

   // One cycle: drive at negedge, model the edge, observe at next negedge
   task automatic step(input bit v, input int s, input logic signed [31:0] lfo,
                       output bit ov, output int os, output exp_t e);
      exp_t x;
      bus.i_valid  = v;
      bus.i_sample = 16'(s);
      bus.i_lfo    = lfo;
      @(posedge clk);
      model_edge(v, bus.i_start, int'(bus.i_depth));
      x.v = v;
      x.s = v ? ref_out(s, lfo, m_eff) : 0;
      exq.push_back(x);
      e = exq.pop_front();
      @(negedge clk);
      ov = bus.o_valid;
      os = int'(bus.o_sample);
   endtask

   // Random stream until the DUT reaches a target depth (or bypass), bounded
   task automatic stream_random(input string tag, input int target, input bit to_bypass, input int limit);
      bit ov, v, done;
      int os;
      exp_t e;
      done = 1'b0;
      for (int k = 0; k < limit && !done; k++) begin
         done = to_bypass ? !bus.o_active : (int'(bus.o_eff_depth) == target);
         if (!done) begin
            v = ($urandom_range(3) != 0);
            step(v, rand_sample(), rand_lfo(), ov, os, e);
            n_checks++;
            if (ov !== e.v || (e.v && os !== e.s))
               $display("FAIL %s_out: got v=%0b s=%0d, want v=%0b s=%0d", tag, ov, os, e.v, e.s);
            else n_pass++;
            n_checks++;
            if ({bus.o_active, bus.o_eff_depth} !== {1'(m_mode != MODE_BYP), 3'(m_eff)})
               $display("FAIL %s_status: got active=%0b depth=%0d, want active=%0b depth=%0d",
                        tag, bus.o_active, bus.o_eff_depth, m_mode != MODE_BYP, m_eff);
            else n_pass++;
         end
      end
      n_checks++;
      if (!done && (to_bypass ? bus.o_active : (int'(bus.o_eff_depth) != target)))
         $display("FAIL %s_timeout: got depth=%0d active=%0b, want depth=%0d bypass=%0b",
                  tag, bus.o_eff_depth, bus.o_active, target, to_bypass);
      else n_pass++;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %0b, want 0", bus.o_valid);
      else n_pass++;
      n_checks++;
      if (bus.o_sample !== 16'sd0) $display("FAIL reset_sample: got %0d, want 0", bus.o_sample);
      else n_pass++;
      n_checks++;
      if (bus.o_active !== 1'b0) $display("FAIL reset_active: got %0b, want 0", bus.o_active);
      else n_pass++;
      n_checks++;
      if (bus.o_eff_depth !== 3'd0) $display("FAIL reset_depth: got %0d, want 0", bus.o_eff_depth);
      else n_pass++;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_bypass();
      int   fixed[3];
      bit   ov, v;
      int   os, s;
      exp_t e;
      fixed = '{1000, -32768, 32767};
      bus.i_start = 1'b0;
      bus.i_depth = 3'($urandom_range(7));
      for (int k = 0; k < 40; k++) begin
         v = (k < 3) ? 1'b1 : (k < 36) ? ($urandom_range(3) != 0) : 1'b0;
         s = (k < 3) ? fixed[k] : rand_sample();
         step(v, s, rand_lfo(), ov, os, e);
         n_checks++;
         if (ov !== e.v || (e.v && os !== e.s))
            $display("FAIL bypass_out: got v=%0b s=%0d, want v=%0b s=%0d", ov, os, e.v, e.s);
         else n_pass++;
         if (k >= 2 && k < 5) begin
            n_checks++;
            if (ov !== 1'b1 || os !== fixed[k-2])
               $display("FAIL bypass_passthru: got v=%0b s=%0d, want v=1 s=%0d", ov, os, fixed[k-2]);
            else n_pass++;
         end
         n_checks++;
         if (bus.o_active !== 1'b0 || bus.o_eff_depth !== 3'd0)
            $display("FAIL bypass_status: got active=%0b depth=%0d, want 0/0", bus.o_active, bus.o_eff_depth);
         else n_pass++;
      end
   endtask

   task automatic test_ramp_up();
      bit   ov, v;
      int   os, n;
      exp_t e;
      bus.i_start = 1'b1;
      bus.i_depth = 3'd7;
      n = 0;
      for (int k = 0; k < 6000 && n < 1800; k++) begin
         v = (k == 0) ? 1'b0 : ($urandom_range(3) != 0);
         step(v, rand_sample(), rand_lfo(), ov, os, e);
         if (v) n++;
         n_checks++;
         if (ov !== e.v || (e.v && os !== e.s))
            $display("FAIL ramp_out: got v=%0b s=%0d, want v=%0b s=%0d", ov, os, e.v, e.s);
         else n_pass++;
         if (v && (n == 1791 || n == 1792)) begin
            n_checks++;
            if (int'(bus.o_eff_depth) != n / 256)
               $display("FAIL ramp_depth_at_%0d: got %0d, want %0d", n, bus.o_eff_depth, n / 256);
            else n_pass++;
         end
      end
      for (int j = 0; j < 3; j++) begin
         step(j == 0, 16384, LFO_MIN, ov, os, e);
         n_checks++;
         if (ov !== e.v || (e.v && os !== e.s))
            $display("FAIL ramp_final_model: got v=%0b s=%0d, want v=%0b s=%0d", ov, os, e.v, e.s);
         else n_pass++;
      end
      n_checks++;
      if (ov !== 1'b1 || os !== EXP_FULL)
         $display("FAIL ramp_final: got v=%0b s=%0d, want v=1 s=%0d", ov, os, EXP_FULL);
      else n_pass++;
   endtask

   task automatic test_depth_four();
      bit   ov;
      int   os;
      exp_t e;
      bus.i_depth = 3'd4;
      stream_random("depth4", 4, 1'b0, 3000);
      for (int j = 0; j < 3; j++) step(j == 0, -8000, 32'sd0, ov, os, e);
      n_checks++;
      if (ov !== 1'b1 || os !== EXP_D4 || os !== e.s)
         $display("FAIL depth4_gain: got v=%0b s=%0d, want v=1 s=%0d", ov, os, EXP_D4);
      else n_pass++;
      bus.i_depth = 3'($urandom_range(7));
      for (int j = 0; j < 3; j++) step(j == 0, 12345, LFO_REST, ov, os, e);
      n_checks++;
      if (ov !== 1'b1 || os !== 12345)
         $display("FAIL rest_unity: got v=%0b s=%0d, want v=1 s=12345", ov, os);
      else n_pass++;
   endtask

   task automatic test_release();
      bit   ov;
      int   os;
      exp_t e;
      bus.i_depth = 3'd7;
      stream_random("climb7", 7, 1'b0, 3000);
      bus.i_start = 1'b0;
      stream_random("release3", 3, 1'b0, 4000);
      bus.i_start = 1'b1;
      step(1'b0, 0, 32'sd0, ov, os, e);
      n_checks++;
      if (bus.o_active !== 1'b1 || bus.o_eff_depth !== 3'd3)
         $display("FAIL restart_hold: got active=%0b depth=%0d, want 1/3", bus.o_active, bus.o_eff_depth);
      else n_pass++;
      stream_random("reclimb4", 4, 1'b0, 1000);
      bus.i_start = 1'b0;
      stream_random("release_end", 0, 1'b1, 6000);
      step(1'b0, 0, 32'sd0, ov, os, e);
      n_checks++;
      if (bus.o_active !== 1'b0 || bus.o_eff_depth !== 3'd0)
         $display("FAIL release_bypass: got active=%0b depth=%0d, want 0/0", bus.o_active, bus.o_eff_depth);
      else n_pass++;
   endtask

   task automatic test_midstream_reset();
      bit   ov;
      int   os;
      exp_t e;
      bus.i_start = 1'b1;
      bus.i_depth = 3'd7;
      stream_random("pre_reset", 1, 1'b0, 1000);
      step(1'b1, rand_sample(), rand_lfo(), ov, os, e);
      step(1'b1, rand_sample(), rand_lfo(), ov, os, e);
      bus.i_valid = 1'b0;
      rst_n = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.o_valid, bus.o_sample, bus.o_active, bus.o_eff_depth} !== '0)
            $display("FAIL midreset_outputs: got v=%0b s=%0d active=%0b depth=%0d, want all 0",
                     bus.o_valid, bus.o_sample, bus.o_active, bus.o_eff_depth);
         else n_pass++;
      end
      bus.i_start = 1'b0;
      rst_n = 1'b1;
      model_reset();
      for (int j = 0; j < 4; j++) begin
         step(1'b0, 0, 32'sd0, ov, os, e);
         n_checks++;
         if (ov !== 1'b0 || bus.o_active !== 1'b0)
            $display("FAIL midreset_after: got v=%0b active=%0b, want 0/0", ov, bus.o_active);
         else n_pass++;
      end
   endtask

   initial begin
      bus.i_start  = 1'b0;
      bus.i_depth  = 3'd0;
      bus.i_lfo    = 32'sd0;
      bus.i_valid  = 1'b0;
      bus.i_sample = 16'sd0;
      model_reset();
      test_reset();
      test_bypass();
      test_ramp_up();
      test_depth_four();
      test_release();
      test_midstream_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
